spi_slave_regs: RTL
===================

# spi_slave_regs

SPI responder for the 4-wire SPI controller's frame format: 8-bit address byte, 4-clock idle gap, 8-bit data byte, both LSB first, SCLK idle high. Address bit 7 selects write (1) or read (0); bits [3:0] index a local register file. Sits in the peripheral device, oversampling SCLK in its own system clock domain. It also exposes a local port so device logic can read and update the registers.

## Interface
- DATA_WIDTH, 8, byte width; only 8 supported
- NUM_REGS, 16, register file depth; addresses 0..NUM_REGS-1 valid
- SYNC_STAGES, 2, synchronizer depth for sclk_i, mosi_i, ss_n_i (>=2)
- pclk_i  in  1  system clock; must be >= 4x SCLK frequency
- prst_i  in  1  reset, asynchronous, active-high
- sclk_i  in  1  SPI clock from master, idle high
- mosi_i  in  1  serial data from master
- ss_n_i  in  1  slave select, active-low; high aborts/idles the frame
- miso_o  out  1  serial data to master; 1 when not driving read data
- loc_addr_i  in  4  local register index
- loc_we_i  in  1  local write strobe
- loc_wdata_i  in  8  local write data
- loc_rdata_o  out  8  registered read of regs[loc_addr_i], 1-cycle latency
- wr_valid_o  out  1  1-cycle pulse: SPI write committed
- wr_addr_o  out  4  register index of committed write
- wr_data_o  out  8  data of committed write
- rd_done_o  out  1  1-cycle pulse: SPI read byte fully shifted out
- addr_err_o  out  1  1-cycle pulse: frame targeted index >= NUM_REGS

## Operation
- Inputs pass through SYNC_STAGES flops; SCLK falling edge detected as sync_sclk previous=1, current=0 (fall_evt). mosi sample uses the synchronized mosi at fall_evt.
- FSM states: S_IDLE, S_ADDR, S_DATA.
- S_IDLE: bit_cnt=0, miso_o=1. sync ss_n=0 -> S_ADDR.
- S_ADDR: each fall_evt shifts mosi into addr_sr[bit_cnt] (LSB first), bit_cnt++. On 8th fall_evt: latch addr, bit_cnt=0 -> S_DATA. If read (addr[7]=0) load tx_sr=regs[addr[3:0]] (0xFF if out of range) and drive miso_o=tx_sr[0] on the next cycle.
- S_DATA write: each fall_evt shifts mosi into data_sr LSB first. On 8th: if index valid, regs[idx]=data, wr_valid_o pulse with wr_addr_o/wr_data_o; else addr_err_o pulse, no write.
- S_DATA read: each fall_evt advances tx_sr and drives next bit on miso_o; on 8th fall_evt rd_done_o pulse (addr_err_o pulse instead if out of range), miso_o=1.
- After data byte: bit_cnt=0 -> S_ADDR (ss_n may stay low across many transactions; gap clocks carry no SCLK edges and are ignored).
- sync ss_n=1 in any state -> S_IDLE next cycle; partial frame discarded, no pulses, no register change.
- Index uses addr[3:0]; addr[6:4] nonzero or index >= NUM_REGS counts as out of range.
- Local write and SPI commit same cycle same index: SPI wins; different index: both take effect.
- loc_rdata_o reflects writes from the previous cycle (no bypass).

## Timing
- Reset (async assert, sync-free deassert): state=S_IDLE, regs all 0x00, miso_o=1, loc_rdata_o=0, wr_valid_o=rd_done_o=addr_err_o=0, wr_addr_o=0, wr_data_o=0, synchronizer flops=1.
- SCLK edge-to-fall_evt latency: SYNC_STAGES+1 pclk cycles.
- Write commit: regs and wr_valid_o update 1 pclk after the 8th data fall_evt.
- miso_o updates 1 pclk after each fall_evt, so it is stable well before the master's next SCLK rising sample given pclk >= 4x SCLK; first read bit valid during the 4-clock gap.
- Pulse outputs are exactly one pclk wide; never two in the same cycle.

## Test plan
- Write: ss_n=0, send addr 0x85, gap, data 0xA5 -> wr_valid_o pulse, wr_addr_o=5, wr_data_o=0xA5; loc_addr_i=5 gives loc_rdata_o=0xA5.
- Read: preload reg 3=0x3C via local port, send addr 0x03 -> miso_o bits 0,0,1,1,1,1,0,0 across data clocks, rd_done_o pulse, regs unchanged.
- Back-to-back: ss_n held low, write 0x81/0x11 then read 0x01 -> second frame returns 0x11 on miso_o.
- Out of range: send 0x9F/0x55 -> addr_err_o pulse, no wr_valid_o, all regs unchanged; read 0x1F -> miso_o all 1s, addr_err_o pulse.
- Abort: ss_n high after 5 data bits of write 0x82/0xFF -> no pulse, reg 2 unchanged; next full frame decodes correctly.
- Reset mid-frame: assert prst_i during address byte -> all outputs at reset values immediately, regs cleared, next frame after release decodes correctly.

Source files
------------

// File: rtl/spi_slave_regs_if.sv
// Signal bundle for spi_slave_regs: SPI pins, local register port and commit/status pulses.
// The slave modport is the responder's view; the master modport is the driver's view.
interface spi_slave_regs_if #(
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 4
);
  logic                  sclk_i;
  logic                  mosi_i;
  logic                  ss_n_i;
  logic                  miso_o;
  logic [IDX_WIDTH-1:0]  loc_addr_i;
  logic                  loc_we_i;
  logic [DATA_WIDTH-1:0] loc_wdata_i;
  logic [DATA_WIDTH-1:0] loc_rdata_o;
  logic                  wr_valid_o;
  logic [IDX_WIDTH-1:0]  wr_addr_o;
  logic [DATA_WIDTH-1:0] wr_data_o;
  logic                  rd_done_o;
  logic                  addr_err_o;

  modport slave (
    input  sclk_i, mosi_i, ss_n_i, loc_addr_i, loc_we_i, loc_wdata_i,
    output miso_o, loc_rdata_o, wr_valid_o, wr_addr_o, wr_data_o, rd_done_o, addr_err_o
  );

  modport master (
    output sclk_i, mosi_i, ss_n_i, loc_addr_i, loc_we_i, loc_wdata_i,
    input  miso_o, loc_rdata_o, wr_valid_o, wr_addr_o, wr_data_o, rd_done_o, addr_err_o
  );
endinterface

// File: rtl/spi_slave_regs.sv
// SPI responder with a local register file: oversamples SCLK in the pclk domain, decodes
// address/data frames (LSB first, sample on SCLK fall) and offers a local read/write port.
//
// state  | meaning
// S_IDLE | slave select inactive; miso held high
// S_ADDR | shifting in the address byte
// S_DATA | shifting data in (write) or out on miso (read)
module spi_slave_regs #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_REGS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic              pclk_i,
  input logic              prst_i,
  spi_slave_regs_if.slave  bus
);
  localparam int DW = DATA_WIDTH;
  localparam logic [2:0] LAST_BIT = 3'(DW - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_n_sync;
  logic                   sclk_q;
  logic [2:0]             bit_cnt;
  logic [DW-2:0]          addr_sr, data_sr, tx_sr;
  logic [DW-1:0]          addr_q;
  logic [DW-1:0]          regs [NUM_REGS];

  logic          sync_sclk, sync_mosi, sync_ss_n, fall_evt, last_evt, spi_commit;
  logic [DW-1:0] addr_full, data_full, rd_val;

  // Index is only valid when the unused address bits are clear and it fits the file.
  function automatic logic idx_ok(input logic [DW-1:0] a);
    return (a[6:4] == 3'b000) && (int'(a[3:0]) < NUM_REGS);
  endfunction

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      sclk_sync <= '1;
      mosi_sync <= '1;
      ss_n_sync <= '1;
      sclk_q    <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi_i};
      ss_n_sync <= {ss_n_sync[SYNC_STAGES-2:0], bus.ss_n_i};
      sclk_q    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign sync_sclk  = sclk_sync[SYNC_STAGES-1];
  assign sync_mosi  = mosi_sync[SYNC_STAGES-1];
  assign sync_ss_n  = ss_n_sync[SYNC_STAGES-1];
  assign fall_evt   = sclk_q & ~sync_sclk;
  assign last_evt   = fall_evt && (bit_cnt == LAST_BIT);
  assign addr_full  = {sync_mosi, addr_sr};
  assign data_full  = {sync_mosi, data_sr};
  assign rd_val     = idx_ok(addr_full) ? regs[addr_full[3:0]] : '1;
  assign spi_commit = !sync_ss_n && (state == S_DATA) && last_evt && addr_q[DW-1] && idx_ok(addr_q);

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      state          <= S_IDLE;
      bit_cnt        <= '0;
      addr_sr        <= '0;
      data_sr        <= '0;
      tx_sr          <= '1;
      addr_q         <= '0;
      bus.miso_o     <= 1'b1;
      bus.wr_valid_o <= 1'b0;
      bus.wr_addr_o  <= '0;
      bus.wr_data_o  <= '0;
      bus.rd_done_o  <= 1'b0;
      bus.addr_err_o <= 1'b0;
    end else begin
      bus.wr_valid_o <= 1'b0;
      bus.rd_done_o  <= 1'b0;
      bus.addr_err_o <= 1'b0;
      if (sync_ss_n) begin
        state      <= S_IDLE;
        bit_cnt    <= '0;
        bus.miso_o <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            bit_cnt    <= '0;
            bus.miso_o <= 1'b1;
            state      <= S_ADDR;
          end
          S_ADDR: begin
            if (fall_evt) begin
              addr_sr <= {sync_mosi, addr_sr[DW-2:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (last_evt) begin
                addr_q  <= addr_full;
                bit_cnt <= '0;
                state   <= S_DATA;
                // Read: first bit goes out during the inter-byte gap.
                if (!sync_mosi) begin
                  tx_sr      <= rd_val[DW-1:1];
                  bus.miso_o <= rd_val[0];
                end
              end
            end
          end
          S_DATA: begin
            if (fall_evt) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (addr_q[DW-1]) begin
                data_sr <= {sync_mosi, data_sr[DW-2:1]};
              end else begin
                bus.miso_o <= tx_sr[0];
                tx_sr      <= {1'b1, tx_sr[DW-2:1]};
              end
              if (last_evt) begin
                bit_cnt    <= '0;
                state      <= S_ADDR;
                bus.miso_o <= 1'b1;
                if (!idx_ok(addr_q)) begin
                  bus.addr_err_o <= 1'b1;
                end else if (addr_q[DW-1]) begin
                  bus.wr_valid_o <= 1'b1;
                  bus.wr_addr_o  <= addr_q[3:0];
                  bus.wr_data_o  <= data_full;
                end else begin
                  bus.rd_done_o <= 1'b1;
                end
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // SPI commit is applied after the local write so it wins on an index collision.
  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      bus.loc_rdata_o <= '0;
    end else begin
      if (bus.loc_we_i && (int'(bus.loc_addr_i) < NUM_REGS)) regs[bus.loc_addr_i] <= bus.loc_wdata_i;
      if (spi_commit) regs[addr_q[3:0]] <= data_full;
      bus.loc_rdata_o <= (int'(bus.loc_addr_i) < NUM_REGS) ? regs[bus.loc_addr_i] : '0;
    end
  end
endmodule
